// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline execution sequencer: FSM state
// encoding, debug-link command bytes and the default HALT encoding.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

  localparam int NB_STATE = 3;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_FLUSH = 8'h46;  // 'F'

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // States in which the pipeline registers and PC advance.
  function automatic logic pipe_running(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_imem_load_seq.sv
// Instruction-memory load sequencer: owns the write address, forms the
// write strobe from the load stream and flags the last word of a program
// (HALT word written, or the top address written).
module imem_load_seq
  import pipeline_ctrl_pkg::*;
#(
  parameter int               NB_DATA   = 32,
  parameter int               NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,       // clears the address before a new load
  input  logic               active,      // controller is in LOAD
  input  logic               load_valid,
  input  logic [NB_DATA-1:0] load_word,
  output logic               imem_we,
  output logic [NB_ADDR-1:0] imem_addr,
  output logic [NB_DATA-1:0] imem_wdata,
  output logic               seq_done     // this cycle's write ends the load
);

  localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;

  logic [NB_ADDR-1:0] addr;

  // Address register: cleared on start, advances after each write, pinned at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (start) begin
      addr <= '0;
    end else if (imem_we && (addr != ADDR_LAST)) begin
      addr <= addr + 1'b1;
    end
  end

  assign imem_we    = active & load_valid;
  assign imem_addr  = addr;
  assign imem_wdata = active ? load_word : '0;
  assign seq_done   = imem_we && ((load_word == HALT_WORD) || (addr == ADDR_LAST));

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the MIPS pipeline. Takes command bytes from the
// debug link, loads instruction memory, runs or single-steps the pipeline,
// stops on HALT and flushes the pipeline registers.
// Optional feature macro: PIPE_WATCHDOG_EN (RUN watchdog, limit WDT_CYCLES).
//
// Command handshake: a byte is taken on any cycle where i_cmd_valid and
// o_cmd_ready are both high; o_cmd_ready is a pure function of the state
// (IDLE or HALTED) and never depends on i_cmd_valid, and the resulting
// state change appears after the next rising edge.
module pipeline_exec_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter int                 NB_CMD    = 8,
  parameter int                 NB_CNT    = 16,
  parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEFAULT
`ifdef PIPE_WATCHDOG_EN
  ,
  parameter logic [15:0]        WDT_CYCLES = 16'd4096
`endif
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [NB_CMD-1:0]   i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_load_valid,
  input  logic [NB_DATA-1:0]  i_load_word,
  output logic                o_imem_we,
  output logic [NB_ADDR-1:0]  o_imem_addr,
  output logic [NB_DATA-1:0]  o_imem_wdata,
  input  logic                i_halt_detected,
  output logic                o_pipe_enable,
  output logic                o_pipe_flush,
  output logic [NB_CNT-1:0]   o_cycle_count,
  output logic [NB_STATE-1:0] o_state,
  output logic                o_done,
  output logic                o_cmd_err
);

  localparam logic [NB_CNT-1:0] CNT_MAX = '1;

  state_t            state, state_next;
  logic              done_q, done_next;
  logic              err_q, err_next;
  logic              load_start;
  logic              load_done;
  logic              wdt_hit;
  logic              cmd_take;
  logic [NB_CNT-1:0] cycle_cnt;

  imem_load_seq #(
    .NB_DATA   (NB_DATA),
    .NB_ADDR   (NB_ADDR),
    .HALT_WORD (HALT_WORD)
  ) u_load_seq (
    .clk        (i_clk),
    .reset      (i_reset),
    .start      (load_start),
    .active     (state == ST_LOAD),
    .load_valid (i_load_valid),
    .load_word  (i_load_word),
    .imem_we    (o_imem_we),
    .imem_addr  (o_imem_addr),
    .imem_wdata (o_imem_wdata),
    .seq_done   (load_done)
  );

`ifdef PIPE_WATCHDOG_EN
  logic [15:0] wdt_cnt;

  // Watchdog: counts cycles spent in RUN, restarts whenever RUN is left.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state != ST_RUN)) begin
      wdt_cnt <= '0;
    end else if (!wdt_hit) begin
      wdt_cnt <= wdt_cnt + 16'd1;
    end
  end

  assign wdt_hit = (state == ST_RUN) && (wdt_cnt == (WDT_CYCLES - 16'd1));
`else
  assign wdt_hit = 1'b0;
`endif

  assign cmd_take      = i_cmd_valid && o_cmd_ready;
  assign o_cmd_ready   = (state == ST_IDLE) || (state == ST_HALTED);
  assign o_pipe_enable = pipe_running(state);
  assign o_pipe_flush  = (state == ST_FLUSH);
  assign o_state       = state;
  assign o_done        = done_q;
  assign o_cmd_err     = err_q;
  assign o_cycle_count = cycle_cnt;

  // FSM state and completion/error pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      err_q  <= err_next;
    end
  end

  // Next-state decode; halt is only honoured in RUN and STEP, and a halt in
  // the same cycle as a watchdog expiry is treated as a normal completion.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    err_next   = 1'b0;
    load_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_take) begin
          case (i_cmd)
            NB_CMD'(CMD_LOAD):  begin state_next = ST_LOAD; load_start = 1'b1; end
            NB_CMD'(CMD_RUN):   state_next = ST_RUN;
            NB_CMD'(CMD_STEP):  state_next = ST_STEP;
            NB_CMD'(CMD_FLUSH): state_next = ST_FLUSH;
            default:            err_next = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_halt_detected) begin
          state_next = ST_HALTED;
          done_next  = 1'b1;
        end else if (wdt_hit) begin
          state_next = ST_HALTED;
          err_next   = 1'b1;
        end
      end
      ST_STEP: begin
        state_next = i_halt_detected ? ST_HALTED : ST_IDLE;
        done_next  = 1'b1;
      end
      ST_HALTED: begin
        if (cmd_take) begin
          case (i_cmd)
            NB_CMD'(CMD_FLUSH): state_next = ST_FLUSH;
            NB_CMD'(CMD_LOAD):  begin state_next = ST_LOAD; load_start = 1'b1; end
            default:            err_next = 1'b1;
          endcase
        end
      end
      ST_FLUSH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Executed-cycle counter: saturating, cleared by reset and by FLUSH.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state == ST_FLUSH)) begin
      cycle_cnt <= '0;
    end else if (o_pipe_enable && (cycle_cnt != CNT_MAX)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Bench for pipeline_exec_ctrl: directed scenarios followed by a random
// command mix, all checked against a transaction-level reference model.
module tb_pipeline_exec_ctrl;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam int NB_CMD  = 8;
  localparam int NB_CNT  = 6;
  localparam int CNT_MAX = (1 << NB_CNT) - 1;
  localparam int ADDR_MAX = (1 << NB_ADDR) - 1;
  localparam logic [NB_DATA-1:0] HALT = 32'hFFFF_FFFF;
  localparam logic [7:0] C_L = 8'h4C, C_R = 8'h52, C_S = 8'h53, C_F = 8'h46;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_STEP = 3, S_HALTED = 4, S_FLUSH = 5;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_cmd_valid = 1'b0;
  logic [NB_CMD-1:0]  i_cmd = '0;
  logic               o_cmd_ready;
  logic               i_load_valid = 1'b0;
  logic [NB_DATA-1:0] i_load_word = '0;
  logic               o_imem_we;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic [NB_DATA-1:0] o_imem_wdata;
  logic               i_halt_detected = 1'b0;
  logic               o_pipe_enable;
  logic               o_pipe_flush;
  logic [NB_CNT-1:0]  o_cycle_count;
  logic [2:0]         o_state;
  logic               o_done;
  logic               o_cmd_err;

  always #5 clk = ~clk;

  pipeline_exec_ctrl #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .NB_CMD  (NB_CMD),
    .NB_CNT  (NB_CNT)
`ifdef PIPE_WATCHDOG_EN
    ,
    .WDT_CYCLES (16'd16)
`endif
  ) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_cmd_valid     (i_cmd_valid),
    .i_cmd           (i_cmd),
    .o_cmd_ready     (o_cmd_ready),
    .i_load_valid    (i_load_valid),
    .i_load_word     (i_load_word),
    .o_imem_we       (o_imem_we),
    .o_imem_addr     (o_imem_addr),
    .o_imem_wdata    (o_imem_wdata),
    .i_halt_detected (i_halt_detected),
    .o_pipe_enable   (o_pipe_enable),
    .o_pipe_flush    (o_pipe_flush),
    .o_cycle_count   (o_cycle_count),
    .o_state         (o_state),
    .o_done          (o_done),
    .o_cmd_err       (o_cmd_err)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [NB_ADDR+NB_DATA-1:0] exp_q[$];
  logic [NB_DATA-1:0] load_list[$];
  int m_state = S_IDLE;
  int m_count = 0;
  int m_addr  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".state"}, 64'(o_state), 64'(m_state));
    check({tag, ".count"}, 64'(o_cycle_count), 64'(m_count));
    check({tag, ".ready"}, 64'(o_cmd_ready), 64'((m_state == S_IDLE) || (m_state == S_HALTED)));
    check({tag, ".enable"}, 64'(o_pipe_enable), 64'((m_state == S_RUN) || (m_state == S_STEP)));
  endtask

  // ---------------- driver tasks ----------------
  // Presents one command for one cycle; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    check("cmd_ready", 64'(o_cmd_ready), 64'd1);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd = NB_CMD'($urandom);
  endtask

  function automatic logic [NB_DATA-1:0] rand_word();
    logic [NB_DATA-1:0] w;
    w = $urandom;
    while (w == HALT) w = $urandom;
    return w;
  endfunction

  // Loads the words in load_list; the load terminates where the model says so.
  task automatic do_load(input string tag);
    logic [NB_DATA-1:0] w;
    logic term;
    send_cmd(C_L);
    m_state = S_LOAD;
    m_addr  = 0;
    check({tag, ".load_state"}, 64'(o_state), 64'(S_LOAD));
    foreach (load_list[i]) begin
      repeat ($urandom_range(0, 2)) begin
        #1 check({tag, ".idle_we"}, 64'(o_imem_we), 64'd0);
        @(negedge clk);
      end
      w = load_list[i];
      i_load_valid = 1'b1;
      i_load_word  = w;
      exp_q.push_back({NB_ADDR'(m_addr), w});
      term = (w == HALT) || (m_addr == ADDR_MAX);
      #1 check({tag, ".we"}, 64'(o_imem_we), 64'd1);
      if (exp_q.size() > 0) check({tag, ".write"}, 64'({o_imem_addr, o_imem_wdata}), 64'(exp_q.pop_front()));
      @(negedge clk);
      i_load_valid = 1'b0;
      i_load_word  = '0;
      if (m_addr < ADDR_MAX) m_addr++;
      if (term) begin
        m_state = S_IDLE;
        check({tag, ".load_done"}, 64'(o_done), 64'd1);
        check_status({tag, ".after_load"});
        break;
      end else begin
        check({tag, ".load_busy"}, 64'(o_state), 64'(S_LOAD));
      end
    end
  endtask

  task automatic do_step(input logic halt, input string tag);
    send_cmd(C_S);
    check({tag, ".step_state"}, 64'(o_state), 64'(S_STEP));
    check({tag, ".step_en"}, 64'(o_pipe_enable), 64'd1);
    i_halt_detected = halt;
    @(negedge clk);
    i_halt_detected = 1'b0;
    m_count = sat_add(m_count, 1);
    m_state = halt ? S_HALTED : S_IDLE;
    check({tag, ".step_done"}, 64'(o_done), 64'd1);
    check_status({tag, ".after_step"});
  endtask

  // Runs for n enabled cycles, halt raised in the n-th.
  task automatic do_run(input int n, input string tag);
    send_cmd(C_R);
    for (int k = 1; k <= n; k++) begin
      check({tag, ".run_en"}, 64'(o_pipe_enable), 64'd1);
      check({tag, ".run_state"}, 64'(o_state), 64'(S_RUN));
      if (k == n) i_halt_detected = 1'b1;
      @(negedge clk);
    end
    i_halt_detected = 1'b0;
    m_count = sat_add(m_count, n);
    m_state = S_HALTED;
    check({tag, ".run_done"}, 64'(o_done), 64'd1);
    check({tag, ".run_err"}, 64'(o_cmd_err), 64'd0);
    check_status({tag, ".after_run"});
  endtask

  task automatic do_flush(input string tag);
    send_cmd(C_F);
    check({tag, ".flush_hi"}, 64'(o_pipe_flush), 64'd1);
    check({tag, ".flush_state"}, 64'(o_state), 64'(S_FLUSH));
    check({tag, ".flush_en"}, 64'(o_pipe_enable), 64'd0);
    @(negedge clk);
    m_count = 0;
    m_state = S_IDLE;
    check({tag, ".flush_lo"}, 64'(o_pipe_flush), 64'd0);
    check_status({tag, ".after_flush"});
  endtask

  // Illegal command; a stray halt indication at the same time must be ignored.
  task automatic do_bad(input logic [7:0] c, input string tag);
    i_halt_detected = 1'($urandom_range(0, 1));
    send_cmd(c);
    i_halt_detected = 1'b0;
    check({tag, ".err"}, 64'(o_cmd_err), 64'd1);
    check({tag, ".err_done"}, 64'(o_done), 64'd0);
    check_status({tag, ".after_bad"});
  endtask

  function automatic logic [7:0] rand_bad(input logic halted);
    logic [7:0] c;
    c = 8'($urandom);
    while (c == C_L || c == C_F || (!halted && (c == C_R || c == C_S))) c = 8'($urandom);
    return c;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    #1;
    check_status("reset");
    check("reset.done", 64'(o_done), 64'd0);
    check("reset.err", 64'(o_cmd_err), 64'd0);
    check("reset.flush", 64'(o_pipe_flush), 64'd0);
    check("reset.we", 64'(o_imem_we), 64'd0);
    check("reset.addr", 64'(o_imem_addr), 64'd0);
    check("reset.wdata", 64'(o_imem_wdata), 64'd0);

    // Two-word program ending in HALT.
    load_list = '{32'h2001_0005, HALT};
    do_load("t1");

    // Single steps.
    repeat (3) do_step(1'b0, "t2");

    // Run until halt, then an illegal STEP.
    do_run(10, "t3");
    do_bad(C_S, "t3b");
    do_bad(C_R, "t3c");

    do_flush("t4");

    // Reset in the middle of a load.
    load_list = {};
    repeat (5) load_list.push_back(rand_word());
    do_load("t5a");
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    m_state = S_IDLE;
    m_count = 0;
    #1;
    check("t5.we", 64'(o_imem_we), 64'd0);
    check("t5.done", 64'(o_done), 64'd0);
    check_status("t5.reset");
    load_list = '{32'h1234_5678, HALT};
    do_load("t5b");

    // Whole memory without HALT: must end on the top address.
    load_list = {};
    repeat (ADDR_MAX + 1) load_list.push_back(rand_word());
    do_load("full");

    // Saturation of the cycle counter.
    for (int r = 0; r < 6; r++) begin
      do_run(12, "sat");
      load_list = '{HALT};
      do_load("sat_ld");
    end
    check("sat.count", 64'(o_cycle_count), 64'(CNT_MAX));

    // Random command mix.
    for (int it = 0; it < 60; it++) begin
      if (m_state == S_IDLE) begin
        case ($urandom_range(0, 4))
          0: begin
            load_list = {};
            repeat ($urandom_range(0, 5)) load_list.push_back(rand_word());
            load_list.push_back(HALT);
            do_load("rnd");
          end
          1: do_step(1'($urandom_range(0, 3) == 0), "rnd");
          2: do_run($urandom_range(1, 12), "rnd");
          3: do_flush("rnd");
          default: do_bad(rand_bad(1'b0), "rnd");
        endcase
      end else begin
        case ($urandom_range(0, 2))
          0: do_flush("rnd");
          1: begin
            load_list = '{rand_word(), HALT};
            do_load("rnd");
          end
          default: begin
            case ($urandom_range(0, 2))
              0: do_bad(C_R, "rnd");
              1: do_bad(C_S, "rnd");
              default: do_bad(rand_bad(1'b1), "rnd");
            endcase
          end
        endcase
      end
    end

`ifdef PIPE_WATCHDOG_EN
    // Watchdog expiry after 16 RUN cycles with no halt.
    if (m_state == S_HALTED) do_flush("wdt_pre");
    send_cmd(C_R);
    for (int k = 1; k <= 16; k++) begin
      check("wdt.run_en", 64'(o_pipe_enable), 64'd1);
      @(negedge clk);
    end
    m_count = sat_add(m_count, 16);
    m_state = S_HALTED;
    check("wdt.err", 64'(o_cmd_err), 64'd1);
    check("wdt.done", 64'(o_done), 64'd0);
    check_status("wdt");
`endif

    check("sb.empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
